// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FP32 field helpers, constants, classify function and multiplier state enum.
package fpu_pkg;
  localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
  localparam int          FP_BIAS    = 127;
  localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} fmul_state_t;
  typedef struct packed {
    logic is_nan;
    logic is_inf;
    logic is_zero;
  } fp_class_t;
  function automatic logic fp_sign(input logic [31:0] x);
    return x[31];
  endfunction
  function automatic logic [7:0] fp_exp(input logic [31:0] x);
    return x[30:23];
  endfunction
  function automatic logic [22:0] fp_man(input logic [31:0] x);
    return x[22:0];
  endfunction
  // exp==0 counts as zero: denormals are flushed
  function automatic fp_class_t fp_classify(input logic [31:0] x);
    fp_class_t c;
    c.is_nan  = fp_exp(x) == FP_EXP_MAX && fp_man(x) != 23'd0;
    c.is_inf  = fp_exp(x) == FP_EXP_MAX && fp_man(x) == 23'd0;
    c.is_zero = fp_exp(x) == 8'd0;
    return c;
  endfunction
endpackage

// File: rtl/fpu_mul_pp_step.sv
// fpu_mul_pp_step: one shift-add step, adds BITS_PER_CYCLE partial products at the top and shifts right.
module fpu_mul_pp_step #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [47:0]               acc,
  input  logic [23:0]               ma,
  input  logic [BITS_PER_CYCLE-1:0] mb,
  output logic [47:0]               acc_nx
);
  localparam int W = 48 + BITS_PER_CYCLE;
  logic [W-1:0] sum;
  // accumulator holds A*B_consumed scaled so the shift never drops set bits
  always_comb begin
    sum = W'(acc);
    for (int i = 0; i < BITS_PER_CYCLE; i++) sum = sum + (mb[i] ? W'(ma) << (24 + i) : '0);
    acc_nx = 48'(sum >> BITS_PER_CYCLE);
  end
endmodule

// File: rtl/fpu_mul_seq.sv
// fpu_mul_seq: sequential shift-add IEEE-754 single-precision multiplier with valid/ready handshake.
module fpu_mul_seq
  import fpu_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        flag_invalid,
  output logic        flag_overflow,
  output logic        flag_underflow
);
  localparam int N = 24 / BITS_PER_CYCLE;
  fmul_state_t state, state_nx;
  logic sgn, sgn_in, special, spec_inv, ovf, unf;
  logic [7:0] ea, eb;
  logic [23:0] ma, mb;
  logic [47:0] acc, acc_nx;
  logic [4:0] cnt;
  logic [31:0] spec_res, norm_res;
  logic [22:0] man;
  logic signed [9:0] e;
  fp_class_t ca, cb;
  assign ca = fp_classify(a);
  assign cb = fp_classify(b);
  assign sgn_in = fp_sign(a) ^ fp_sign(b);
  assign special = ca.is_nan | cb.is_nan | ca.is_inf | cb.is_inf | ca.is_zero | cb.is_zero;
  assign spec_inv = ca.is_nan | cb.is_nan | (ca.is_inf & cb.is_zero) | (ca.is_zero & cb.is_inf);
  assign spec_res = spec_inv ? FP_QNAN : (ca.is_inf | cb.is_inf) ? {sgn_in, FP_EXP_MAX, 23'd0} : 32'd0;
  assign e = $signed({2'b0, ea} + {2'b0, eb} + {9'd0, acc[47]} - 10'(FP_BIAS));
  assign man = acc[47] ? acc[46:24] : acc[45:23];
  assign ovf = e >= 10'sd255;
  assign unf = e <= 10'sd0;
  assign norm_res = ovf ? {sgn, FP_EXP_MAX, 23'd0} : unf ? 32'd0 : {sgn, e[7:0], man};
  fpu_mul_pp_step #(.BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
    .acc    (acc),
    .ma     (ma),
    .mb     (mb[BITS_PER_CYCLE-1:0]),
    .acc_nx (acc_nx)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    unique case (state)
      IDLE: if (in_valid) state_nx = special ? DONE : MUL;
      MUL:  if (cnt == 5'(N - 1)) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {sgn, ea, eb, ma, mb, acc, cnt} <= '0;
      {result, flag_invalid, flag_overflow, flag_underflow} <= '0;
    end else if (state == IDLE && in_valid) begin
      sgn <= sgn_in;
      ea <= fp_exp(a);
      eb <= fp_exp(b);
      ma <= {1'b1, fp_man(a)};
      mb <= {1'b1, fp_man(b)};
      acc <= '0;
      cnt <= '0;
      if (special) {result, flag_invalid, flag_overflow, flag_underflow} <= {spec_res, spec_inv, 2'b00};
    end else if (state == MUL) begin
      acc <= acc_nx;
      mb <= mb >> BITS_PER_CYCLE;
      cnt <= cnt + 5'd1;
    end else if (state == NORM) begin
      {result, flag_invalid, flag_overflow, flag_underflow} <= {norm_res, 1'b0, ovf, unf};
    end
endmodule
